input_buffer_b3_reader: RTL and testbench

Read-side sequencer for the 16-bank layer-3 input buffer (16 single-port RAMs, 32-bit words, 14 rows each). After one `start` command it reads a programmed number of rows from all 16 banks in lockstep, starting at row 0. Each row is returned as one 512-bit beat on a valid/ready stream to the PE array. It handles the fixed RAM read latency and downstream backpressure through a 2-entry skid FIFO, so no read data is dropped or duplicated.

---
 rtl/input_buffer_b3_reader_pkg.sv | 26 ++
 rtl/input_buffer_b3_reader_skid_fifo2.sv | 54 +++++
 rtl/input_buffer_b3_reader.sv | 153 +++++++++++++++
 tb/tb_input_buffer_b3_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_buffer_b3_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package   : ecgai_buf_pkg
// Purpose   : Shared geometry and state encoding for the layer-3 input
//             buffer. Used by both the read sequencer and the write-side
//             controller so both agree on bank count, widths and depth.
// Contents  : BUF_NBANK, BUF_DW, BUF_AW, BUF_DEPTH, rd_state_t
// Revision  : 1.0 - initial release
// ============================================================================
package ecgai_buf_pkg;

  localparam int BUF_NBANK = 16;  // RAM banks read in lockstep
  localparam int BUF_DW    = 32;  // data width per bank
  localparam int BUF_AW    = 4;   // RAM address width
  localparam int BUF_DEPTH = 14;  // valid rows per bank

  // Reader sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/input_buffer_b3_reader_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module    : skid_fifo2
// Purpose   : Two-entry first-in first-out buffer that absorbs the read data
//             already in flight when the downstream consumer stalls.
// Ports     : clk, rst_n  - clock, asynchronous active-low clear
//             push, din   - write an entry (never issued when full)
//             pop         - drop the head entry (never issued when empty)
//             head        - oldest entry, stable until popped
//             count       - number of valid entries (0..2)
// Revision  : 1.0 - initial release
// ============================================================================
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head is read straight from storage so it is zero after reset and holds
  // still while the consumer stalls.
  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/input_buffer_b3_reader.sv
`default_nettype none
// ============================================================================
// Module    : input_buffer_b3_reader
// Purpose   : Read-side sequencer for the 16-bank layer-3 input buffer. One
//             start command reads rows 0..len-1 from all banks in lockstep and
//             streams each row as one wide beat on a valid/ready interface.
// Ports     : clk, rst_n            - clock, asynchronous active-low reset
//             start, rd_len         - command pulse and row count (clamped)
//             busy, done            - command in progress / completion pulse
//             ram_ena, ram_wea      - per-bank enable / write enable (0)
//             ram_addr, ram_dout    - per-bank address / read data
//             m_data, m_valid,
//             m_ready, m_last       - output beat stream to the PE array
// Revision  : 1.0 - initial release
// ============================================================================
module input_buffer_b3_reader
  import ecgai_buf_pkg::*;
#(
  parameter int NBANK  = BUF_NBANK,
  parameter int DW     = BUF_DW,
  parameter int AW     = BUF_AW,
  parameter int DEPTH  = BUF_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       rd_len,
  output logic                busy,
  output logic                done,
  output logic [NBANK-1:0]    ram_ena,
  output logic [NBANK-1:0]    ram_wea,
  output logic [NBANK*AW-1:0] ram_addr,
  input  logic [NBANK*DW-1:0] ram_dout,
  output logic [NBANK*DW-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int BW = NBANK * DW;

  rd_state_t         state;
  rd_state_t         state_nx;
  logic [AW-1:0]     row;
  logic [AW-1:0]     len;
  logic [AW-1:0]     len_clamped;
  logic [RD_LAT-1:0] lat_vld;    // one bit per read still inside the RAM
  logic [RD_LAT-1:0] lat_last;   // matching last-row flag
  logic [2:0]        inflight;
  logic [2:0]        occupancy;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              push;
  logic              drained;
  logic [1:0]        fifo_count;
  logic [BW:0]       fifo_head;

  assign len_clamped = (rd_len > AW'(DEPTH)) ? AW'(DEPTH) : rd_len;

  // Reads already issued but not yet captured by the FIFO.
  always_comb begin
    inflight = 3'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 3'(lat_vld[i]);
    end
  end

  assign occupancy = 3'(fifo_count) + inflight;
  assign pop       = m_valid & m_ready;
  assign push      = lat_vld[RD_LAT-1];

  // Every issued read is guaranteed a FIFO slot: occupancy after this
  // cycle's pop must leave room for one more. Crediting the same-cycle pop
  // is what lets a 2-entry FIFO sustain one beat per cycle.
  assign issue      = (state == RUN) && (occupancy < (3'd2 + 3'(pop)));
  assign last_issue = issue && (row == (len - AW'(1)));

  // Nothing left to deliver once the current head leaves this cycle.
  assign drained = (inflight == 3'd0) && (fifo_count == {1'b0, pop});

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      len      <= '0;
      lat_vld  <= '0;
      lat_last <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && start) begin
        row <= '0;
        len <= len_clamped;
      end else if (issue && !last_issue) begin
        // Row stops at len-1, which never exceeds DEPTH-1.
        row <= row + AW'(1);
      end
      lat_vld[0]  <= issue;
      lat_last[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        lat_vld[i]  <= lat_vld[i-1];
        lat_last[i] <= lat_last[i-1];
      end
    end
  end

  skid_fifo2 #(
    .W(BW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({lat_last[RD_LAT-1], ram_dout}),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign ram_ena  = {NBANK{issue}};
  assign ram_wea  = '0;
  assign ram_addr = {NBANK{row}};
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign m_valid  = (fifo_count != 2'd0);
  assign m_data   = fifo_head[BW-1:0];
  assign m_last   = m_valid & fifo_head[BW];

endmodule
`default_nettype wire

// File: tb/tb_input_buffer_b3_reader.sv
`default_nettype none
// ============================================================================
// Module    : tb_input_buffer_b3_reader
// Purpose   : Self-checking bench for input_buffer_b3_reader. A behavioural
//             RAM returns {bank, row, A5A5} per bank; expected beats are queued
//             when a command is issued and compared as they are accepted.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_input_buffer_b3_reader;

  localparam int NB = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = NB * DW;
  localparam int XW = BW + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     rd_len = '0;
  logic              m_ready = 1'b1;
  logic              busy, done, m_valid, m_last;
  logic [NB-1:0]     ram_ena, ram_wea;
  logic [NB*AW-1:0]  ram_addr;
  logic [BW-1:0]     ram_dout = '0;
  logic [BW-1:0]     m_data;

  input_buffer_b3_reader #(
    .NBANK(NB), .DW(DW), .AW(AW), .DEPTH(14), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_len(rd_len),
    .busy(busy), .done(done), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Preloaded RAM contents, read latency 1.
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (ram_ena[k]) ram_dout[k*DW +: DW] <= {8'(k), 4'h0, ram_addr[k*AW +: AW], 16'hA5A5};
    end
  end

  int errors = 0;
  int checks = 0;
  logic [XW-1:0] sb[$];

  int   c0 = 0;
  int   beats, done_cnt, done_cyc, first_valid, last_pop, ena_seen, valid_seen;
  logic busy_at1, ena_at1;
  logic prev_stall = 1'b0;
  logic [BW-1:0] prev_data;

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] pat_row(input int r);
    logic [BW-1:0] d;
    for (int k = 0; k < NB; k++) d[k*DW +: DW] = {8'(k), 8'(r), 16'hA5A5};
    return d;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int t;
    logic [XW-1:0] exp;
    if (rst_n) begin
      t = cyc - c0;
      if (t == 1) begin busy_at1 = busy; ena_at1 = ram_ena[0]; end
      if (done) begin done_cnt++; done_cyc = t; end
      if (|ram_ena) begin
        ena_seen++;
        chk("ena_uniform", XW'(ram_ena), XW'({NB{1'b1}}));
        chk("addr_uniform", XW'(ram_addr), XW'({NB{ram_addr[AW-1:0]}}));
        chk("addr_max", XW'(ram_addr[AW-1:0] > 4'd13), XW'(0));
        chk("wea_zero", XW'(ram_wea), XW'(0));
      end
      if (m_valid) begin
        valid_seen++;
        if (first_valid < 0) first_valid = t;
      end
      if (prev_stall) begin
        chk("stall_valid", XW'(m_valid), XW'(1));
        chk("stall_data", XW'(m_data), XW'(prev_data));
      end
      if (m_valid && m_ready) begin
        beats++;
        last_pop = t;
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk("beat", {m_last, m_data}, exp);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  XW'(busy),     XW'(0));
    chk({tag, "_done"},  XW'(done),     XW'(0));
    chk({tag, "_ena"},   XW'(ram_ena),  XW'(0));
    chk({tag, "_wea"},   XW'(ram_wea),  XW'(0));
    chk({tag, "_addr"},  XW'(ram_addr), XW'(0));
    chk({tag, "_valid"}, XW'(m_valid),  XW'(0));
    chk({tag, "_last"},  XW'(m_last),   XW'(0));
    chk({tag, "_data"},  XW'(m_data),   XW'(0));
  endtask

  // Called just after a rising edge: start is high for exactly cycle c0.
  task automatic issue_cmd(input logic [AW-1:0] len, input int nexp);
    for (int r = 0; r < nexp; r++) sb.push_back({(r == nexp - 1), pat_row(r)});
    beats = 0; done_cnt = 0; done_cyc = -1; first_valid = -1; last_pop = -1;
    ena_seen = 0; valid_seen = 0; busy_at1 = 1'b0; ena_at1 = 1'b0;
    c0 = cyc;
    start = 1'b1;
    rd_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    rd_len = '0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    int t;
    for (int i = 0; i < bound && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        t = cyc - c0;
        if (t >= 5 && t < 10) m_ready = 1'b0;
        else m_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", XW'(done_cnt > 0), XW'(1));
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_cmd(input string tag, input int nexp, input int exp_done);
    chk({tag, "_done_cnt"}, XW'(done_cnt), XW'(1));
    chk({tag, "_beats"}, XW'(beats), XW'(nexp));
    chk({tag, "_sb_empty"}, XW'(sb.size()), XW'(0));
    if (exp_done >= 0) chk({tag, "_done_cyc"}, XW'(done_cyc), XW'(exp_done));
    if (nexp > 0) begin
      chk({tag, "_first_valid"}, XW'(first_valid), XW'(3));
      chk({tag, "_done_after_last"}, XW'(done_cyc), XW'(last_pop + 1));
      chk({tag, "_busy_c1"}, XW'(busy_at1), XW'(1));
      chk({tag, "_ena_c1"}, XW'(ena_at1), XW'(1));
    end else begin
      chk({tag, "_no_ena"}, XW'(ena_seen), XW'(0));
      chk({tag, "_no_valid"}, XW'(valid_seen), XW'(0));
      chk({tag, "_done_window"}, XW'(done_cyc >= 1 && done_cyc <= 3), XW'(1));
    end
  endtask

  initial begin
    // Reset state, during and right after reset.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst_idle");

    // Full 14-row read with continuous ready.
    m_ready = 1'b1;
    issue_cmd(4'd14, 14);
    wait_done(100, 1'b0);
    check_cmd("len14", 14, 17);
    chk("len14_last_beat_cyc", XW'(last_pop), XW'(16));

    // Zero-length command.
    issue_cmd(4'd0, 0);
    wait_done(20, 1'b0);
    check_cmd("len0", 0, -1);

    // Over-range length is clamped to the buffer depth.
    issue_cmd(4'd15, 14);
    wait_done(100, 1'b0);
    check_cmd("len15", 14, 17);

    // Random backpressure including a 5-cycle stall.
    issue_cmd(4'd6, 6);
    wait_done(300, 1'b1);
    check_cmd("len6_bp", 6, -1);

    // Second start while running must be ignored.
    issue_cmd(4'd8, 8);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    rd_len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    rd_len = '0;
    wait_done(100, 1'b0);
    check_cmd("restart_ign", 8, 11);

    // Asynchronous reset after the third beat of a 10-row read.
    issue_cmd(4'd10, 10);
    for (int i = 0; i < 50 && beats < 3; i++) @(posedge clk);
    chk("mid_rst_reached", XW'(beats >= 3), XW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("post_rst");

    issue_cmd(4'd4, 4);
    wait_done(100, 1'b0);
    check_cmd("after_rst", 4, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
